// File: rtl/wb_pkg.sv
// Shared definitions for the VLIW writeback path.
//   XLEN          : datapath width of every writeback result
//   NUM_WB_SLOTS  : number of bundle slots / register-file write ports
//   wb_req_t      : one writeback request {we, rd, wd}
//   slot_to_port  : maps a slot index (0..3) to its register-file port number (3/6/9/12)
package wb_pkg;

    localparam int XLEN         = 64;
    localparam int NUM_WB_SLOTS = 4;

    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } wb_req_t;

    function automatic int slot_to_port(input int slot);
        return 3 * (slot + 1);
    endfunction

endpackage

// File: rtl/wb_waw_mask.sv
// Combinational same-destination (WAW) filter for one result bundle.
// Ports:
//   reqs      in   raw per-slot requests, slot 3 is the youngest
//   accept    in   bundle handshake completed this cycle
//   wins      out  requests with we replaced by the effective-write bit
//   eff       out  effective-write mask (bit i = slot i)
//   free_any  out  at least one slot has no effective write
//   free_idx  out  lowest slot index without an effective write
module wb_waw_mask
    import wb_pkg::*;
#(
    parameter bit E_SUPPORTED = 1'b0
) (
    input  wb_req_t [NUM_WB_SLOTS-1:0] reqs,
    input  logic                       accept,
    output wb_req_t [NUM_WB_SLOTS-1:0] wins,
    output logic    [NUM_WB_SLOTS-1:0] eff,
    output logic                       free_any,
    output logic    [1:0]              free_idx
);

    logic [NUM_WB_SLOTS-1:0] legal;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WB_SLOTS; gi++) begin : g_slot
            logic younger_hit;

            // x0 is never written; in E mode x16..x31 do not exist.
            assign legal[gi] = accept && reqs[gi].we && (reqs[gi].rd != 5'd0)
                               && !(E_SUPPORTED && reqs[gi].rd[4]);

            // A younger slot writing the same register masks this one.
            always_comb begin
                younger_hit = 1'b0;
                for (int j = gi + 1; j < NUM_WB_SLOTS; j++) begin
                    if (legal[j] && (reqs[j].rd == reqs[gi].rd)) begin
                        younger_hit = 1'b1;
                    end
                end
            end

            assign eff[gi]  = legal[gi] && !younger_hit;
            assign wins[gi] = '{we: eff[gi], rd: reqs[gi].rd, wd: reqs[gi].wd};
        end
    endgenerate

    // Scan from the top so the lowest free slot is the last one written.
    always_comb begin
        free_any = 1'b0;
        free_idx = 2'd0;
        for (int i = NUM_WB_SLOTS - 1; i >= 0; i--) begin
            if (!eff[i]) begin
                free_any = 1'b1;
                free_idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/vliw_wb_arbiter.sv
// Writeback producer for the 12-port VLIW integer register file.
// Merges a 4-slot FU result bundle with a one-entry long-latency result
// buffer and drives the file's four registered write ports (3/6/9/12).
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   BundleValid/BundleReady         bundle handshake
//   BundleWe/BundleRd/BundleWd      per-slot request (slot i at bit/field i)
//   LongValid/LongReady             long-latency handshake
//   LongRd/LongWd                   long result destination and data
//   we3..we12, a3..a12, wd3..wd12   registered write ports for slots 0..3
module vliw_wb_arbiter
    import wb_pkg::*;
#(
    parameter bit E_SUPPORTED  = 1'b0,
    parameter int STARVE_LIMIT = 4      // must be >= 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         BundleValid,
    output logic                         BundleReady,
    input  logic [NUM_WB_SLOTS-1:0]      BundleWe,
    input  logic [NUM_WB_SLOTS*5-1:0]    BundleRd,
    input  logic [NUM_WB_SLOTS*XLEN-1:0] BundleWd,
    input  logic                         LongValid,
    output logic                         LongReady,
    input  logic [4:0]                   LongRd,
    input  logic [XLEN-1:0]              LongWd,
    output logic                         we3,
    output logic                         we6,
    output logic                         we9,
    output logic                         we12,
    output logic [4:0]                   a3,
    output logic [4:0]                   a6,
    output logic [4:0]                   a9,
    output logic [4:0]                   a12,
    output logic [XLEN-1:0]              wd3,
    output logic [XLEN-1:0]              wd6,
    output logic [XLEN-1:0]              wd9,
    output logic [XLEN-1:0]              wd12
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic            buf_valid_reg, buf_valid_next;
    logic [4:0]      buf_rd_reg,    buf_rd_next;
    logic [XLEN-1:0] buf_wd_reg,    buf_wd_next;
    logic [CW-1:0]   starve_cnt_reg, starve_cnt_next;

    logic [NUM_WB_SLOTS-1:0] port_we_reg, port_we_next;
    logic [4:0]              port_rd_reg [NUM_WB_SLOTS];
    logic [4:0]              port_rd_next[NUM_WB_SLOTS];
    logic [XLEN-1:0]         port_wd_reg [NUM_WB_SLOTS];
    logic [XLEN-1:0]         port_wd_next[NUM_WB_SLOTS];

    wb_req_t [NUM_WB_SLOTS-1:0] reqs;
    wb_req_t [NUM_WB_SLOTS-1:0] wins;
    logic    [NUM_WB_SLOTS-1:0] eff;
    logic    [NUM_WB_SLOTS-1:0] rd_hit;
    logic                       free_any;
    logic    [1:0]              free_idx;

    logic starved, accept, long_accept, long_legal;
    logic place, drop;
    logic [1:0] place_slot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WB_SLOTS; gi++) begin : g_req
            assign reqs[gi] = '{we: BundleWe[gi],
                                rd: BundleRd[gi*5 +: 5],
                                wd: BundleWd[gi*XLEN +: XLEN]};
            assign rd_hit[gi] = wins[gi].we && (wins[gi].rd == buf_rd_reg);
        end
    endgenerate

    // Once the buffered result has waited long enough, hold off the bundle
    // for one cycle so the long result gets port 3.
    assign starved     = buf_valid_reg && (starve_cnt_reg == CW'(STARVE_LIMIT));
    assign BundleReady = !starved;
    assign LongReady   = !buf_valid_reg;
    assign accept      = BundleValid && BundleReady;
    assign long_accept = LongValid && LongReady;
    assign long_legal  = (LongRd != 5'd0) && !(E_SUPPORTED && LongRd[4]);

    wb_waw_mask #(.E_SUPPORTED(E_SUPPORTED)) u_waw_mask (
        .reqs     (reqs),
        .accept   (accept),
        .wins     (wins),
        .eff      (eff),
        .free_any (free_any),
        .free_idx (free_idx)
    );

    always_comb begin
        place      = 1'b0;
        drop       = 1'b0;
        place_slot = 2'd0;
        if (buf_valid_reg) begin
            if (|rd_hit) begin
                // The bundle result is younger than the buffered one.
                drop = 1'b1;
            end else if (accept) begin
                if (free_any) begin
                    place      = 1'b1;
                    place_slot = free_idx;
                end
            end else begin
                place = 1'b1;
            end
        end

        buf_valid_next = buf_valid_reg;
        buf_rd_next    = buf_rd_reg;
        buf_wd_next    = buf_wd_reg;
        if (long_accept) begin
            // Writes to x0 or nonexistent registers are swallowed here.
            buf_valid_next = long_legal;
            buf_rd_next    = LongRd;
            buf_wd_next    = LongWd;
        end else if (place || drop) begin
            buf_valid_next = 1'b0;
        end

        starve_cnt_next = starve_cnt_reg;
        if (!buf_valid_reg || place || drop) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != CW'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
        end

        for (int i = 0; i < NUM_WB_SLOTS; i++) begin
            port_we_next[i] = 1'b0;
            port_rd_next[i] = 5'd0;
            port_wd_next[i] = '0;
            if (wins[i].we) begin
                port_we_next[i] = 1'b1;
                port_rd_next[i] = wins[i].rd;
                port_wd_next[i] = wins[i].wd;
            end else if (place && (place_slot == 2'(i))) begin
                port_we_next[i] = 1'b1;
                port_rd_next[i] = buf_rd_reg;
                port_wd_next[i] = buf_wd_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_reg  <= 1'b0;
            buf_rd_reg     <= 5'd0;
            buf_wd_reg     <= '0;
            starve_cnt_reg <= '0;
            port_we_reg    <= '0;
            for (int i = 0; i < NUM_WB_SLOTS; i++) begin
                port_rd_reg[i] <= 5'd0;
                port_wd_reg[i] <= '0;
            end
        end else begin
            buf_valid_reg  <= buf_valid_next;
            buf_rd_reg     <= buf_rd_next;
            buf_wd_reg     <= buf_wd_next;
            starve_cnt_reg <= starve_cnt_next;
            port_we_reg    <= port_we_next;
            for (int i = 0; i < NUM_WB_SLOTS; i++) begin
                port_rd_reg[i] <= port_rd_next[i];
                port_wd_reg[i] <= port_wd_next[i];
            end
        end
    end

    assign we3  = port_we_reg[0];
    assign we6  = port_we_reg[1];
    assign we9  = port_we_reg[2];
    assign we12 = port_we_reg[3];
    assign a3   = port_rd_reg[0];
    assign a6   = port_rd_reg[1];
    assign a9   = port_rd_reg[2];
    assign a12  = port_rd_reg[3];
    assign wd3  = port_wd_reg[0];
    assign wd6  = port_wd_reg[1];
    assign wd9  = port_wd_reg[2];
    assign wd12 = port_wd_reg[3];

endmodule

// File: tb/tb_vliw_wb_arbiter.sv
// Directed self-checking bench for vliw_wb_arbiter (E_SUPPORTED=0, STARVE_LIMIT=4).
module tb_vliw_wb_arbiter;
    import wb_pkg::*;

    logic                         clk;
    logic                         reset;
    logic                         BundleValid;
    logic                         BundleReady;
    logic [NUM_WB_SLOTS-1:0]      BundleWe;
    logic [NUM_WB_SLOTS*5-1:0]    BundleRd;
    logic [NUM_WB_SLOTS*XLEN-1:0] BundleWd;
    logic                         LongValid;
    logic                         LongReady;
    logic [4:0]                   LongRd;
    logic [XLEN-1:0]              LongWd;
    logic                         we3, we6, we9, we12;
    logic [4:0]                   a3, a6, a9, a12;
    logic [XLEN-1:0]              wd3, wd6, wd9, wd12;

    localparam logic [63:0] VA = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] VB = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] VC = 64'hCCCC_0000_0000_0003;
    localparam logic [63:0] VD = 64'hDDDD_0000_0000_0004;
    localparam logic [63:0] VE = 64'hEEEE_0000_0000_0005;
    localparam logic [63:0] VF = 64'hFFFF_0000_0000_0006;
    localparam logic [63:0] VX = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] VY = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] VZ = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] VW = 64'hDEAD_BEEF_CAFE_F00D;

    int checks = 0;
    int errors = 0;

    vliw_wb_arbiter #(.E_SUPPORTED(1'b0), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .BundleValid (BundleValid),
        .BundleReady (BundleReady),
        .BundleWe    (BundleWe),
        .BundleRd    (BundleRd),
        .BundleWd    (BundleWd),
        .LongValid   (LongValid),
        .LongReady   (LongReady),
        .LongRd      (LongRd),
        .LongWd      (LongWd),
        .we3 (we3), .we6 (we6), .we9 (we9), .we12 (we12),
        .a3  (a3),  .a6  (a6),  .a9  (a9),  .a12  (a12),
        .wd3 (wd3), .wd6 (wd6), .wd9 (wd9), .wd12 (wd12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic v, input logic [3:0] we,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] r3,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3);
        BundleValid = v;
        BundleWe    = we;
        BundleRd    = {r3, r2, r1, r0};
        BundleWd    = {d3, d2, d1, d0};
    endtask

    task automatic set_long(input logic v, input logic [4:0] rd, input logic [63:0] wd);
        LongValid = v;
        LongRd    = rd;
        LongWd    = wd;
    endtask

    task automatic chk_ports(input string tag, input logic [3:0] we,
                             input logic [4:0] e0, input logic [4:0] e1,
                             input logic [4:0] e2, input logic [4:0] e3,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3);
        check({tag, ".we"},   64'({we12, we9, we6, we3}), 64'(we));
        check({tag, ".a3"},   64'(a3),  64'(e0));
        check({tag, ".a6"},   64'(a6),  64'(e1));
        check({tag, ".a9"},   64'(a9),  64'(e2));
        check({tag, ".a12"},  64'(a12), 64'(e3));
        check({tag, ".wd3"},  wd3,  d0);
        check({tag, ".wd6"},  wd6,  d1);
        check({tag, ".wd9"},  wd9,  d2);
        check({tag, ".wd12"}, wd12, d3);
    endtask

    task automatic chk_idle(input string tag);
        chk_ports(tag, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        set_bundle(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        set_long(0, 0, 0);

        // Reset state
        #12;
        chk_idle("reset");
        check("reset.bundle_ready", 64'(BundleReady), 64'd1);
        check("reset.long_ready",   64'(LongReady),   64'd1);
        reset = 1'b1;
        cyc();

        // WAW: slot1 beats slot0 on x5, slot2 targets x0, slot3 writes x7
        set_bundle(1, 4'b1111, 5, 5, 0, 7, VA, VB, VC, VD);
        cyc();
        set_bundle(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_ports("waw", 4'b1010, 0, 5, 0, 7, 0, VB, 0, VD);

        // Async reset mid-cycle clears the ports immediately
        #2 reset = 1'b0;
        #1;
        chk_idle("rst_mid");
        check("rst_mid.bundle_ready", 64'(BundleReady), 64'd1);
        check("rst_mid.long_ready",   64'(LongReady),   64'd1);
        #1 reset = 1'b1;
        cyc();

        // Long result takes the lowest free slot (slot 2 -> port 9)
        set_long(1, 9, VX);
        check("long_free.ready_pre", 64'(LongReady), 64'd1);
        cyc();
        set_long(0, 0, 0);
        check("long_free.ready_busy", 64'(LongReady), 64'd0);
        set_bundle(1, 4'b0011, 1, 2, 0, 0, VE, VF, 0, 0);
        cyc();
        set_bundle(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_ports("long_free", 4'b0111, 1, 2, 9, 0, VE, VF, VX, 0);
        check("long_free.ready_post", 64'(LongReady), 64'd1);
        cyc();
        chk_idle("no_hold");

        // Long write to x0 is accepted and dropped
        set_long(1, 0, VX);
        cyc();
        set_long(0, 0, 0);
        check("long_rd0.ready", 64'(LongReady), 64'd1);
        cyc();
        chk_idle("long_rd0");

        // No bundle: long result goes to port 3, output two cycles after accept
        set_long(1, 20, VZ);
        cyc();
        set_long(0, 0, 0);
        cyc();
        chk_ports("long_idle", 4'b0001, 20, 0, 0, 0, VZ, 0, 0, 0);
        check("long_idle.ready", 64'(LongReady), 64'd1);

        // Younger bundle write to the same rd discards the long result
        set_long(1, 9, VX);
        cyc();
        set_long(0, 0, 0);
        set_bundle(1, 4'b0100, 0, 0, 9, 0, 0, 0, VY, 0);
        cyc();
        set_bundle(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_ports("waw_long", 4'b0100, 0, 0, 9, 0, 0, 0, VY, 0);
        check("waw_long.ready", 64'(LongReady), 64'd1);
        cyc();
        chk_idle("waw_long_after");

        // Starvation: four full bundles, then the bundle is stalled once
        set_long(1, 9, VX);
        cyc();
        set_long(0, 0, 0);
        set_bundle(1, 4'b1111, 1, 2, 3, 4, VA, VB, VC, VD);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("starve.ready%0d", k), 64'(BundleReady), 64'd1);
            cyc();
            chk_ports($sformatf("starve.full%0d", k), 4'b1111, 1, 2, 3, 4, VA, VB, VC, VD);
        end
        check("starve.stall", 64'(BundleReady), 64'd0);
        cyc();
        chk_ports("starve_place", 4'b0001, 9, 0, 0, 0, VX, 0, 0, 0);
        check("starve.ready_back", 64'(BundleReady), 64'd1);
        check("starve.long_ready", 64'(LongReady),   64'd1);
        set_bundle(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while a long result is buffered discards it
        set_long(1, 12, VW);
        cyc();
        set_long(0, 0, 0);
        check("rst_buf.busy", 64'(LongReady), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk_idle("rst_buf");
        check("rst_buf.long_ready", 64'(LongReady), 64'd1);
        #1 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("rst_buf.we%0d", k), 64'({we12, we9, we6, we3}), 64'd0);
            check($sformatf("rst_buf.lr%0d", k), 64'(LongReady), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
